// File: rtl/sev_seg_scan.sv
// +----------------------------------------------------------------------------+
// | sev_seg_scan : 4-digit common-anode 7-segment scan controller with a       |
// |                one-deep load buffer committed at frame boundaries.         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module sev_seg_scan #(
  parameter int DIV_CYCLES   = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter bit LZ_SUPPRESS  = 1'b1
) (
  input  logic        CLK_100MHZ,
  input  logic        RST,
  input  logic [15:0] VALUE_IN,
  input  logic        LOAD_VALID,
  output logic        LOAD_READY,
  output logic [3:0]  AN,
  output logic [3:0]  DIGIT,
  output logic        FRAME_TICK
);

  localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic          run_q, run_d;
  logic          pend_full_q, pend_full_d;
  logic [15:0]   pend_q, pend_d;
  logic [15:0]   disp_q, disp_d;
  logic [3:0]    an_q, an_d;
  logic [3:0]    digit_q, digit_d;
  logic          tick_q, tick_d;
  logic          xfer, commit, suppress;

  always_comb begin
    run_d       = 1'b1;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    pend_full_d = pend_full_q;
    pend_d      = pend_q;
    disp_d      = disp_q;
    suppress    = 1'b0;
    an_d        = 4'hF;

    // The first cycle out of reset is itself slot 0, count 0, so the
    // counters hold one cycle before they start advancing.
    if (!run_q) begin
      cnt_d = '0;
      idx_d = 2'd0;
    end else if (cnt_q == CW'(DIV_CYCLES - 1)) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    xfer   = LOAD_VALID & ~pend_full_q;
    commit = tick_q & pend_full_q;
    if (commit) begin
      disp_d      = pend_q;
      pend_full_d = 1'b0;
    end else if (xfer) begin
      pend_d      = VALUE_IN;
      pend_full_d = 1'b1;
    end

    // Outputs are registered from next-state values so they line up with cnt/idx.
    digit_d = disp_d[{idx_d, 2'b00} +: 4];
    case (idx_d)
      2'd3:    suppress = (disp_d[15:12] == 4'h0);
      2'd2:    suppress = (disp_d[15:8] == 8'h00);
      2'd1:    suppress = (disp_d[15:4] == 12'h000);
      default: suppress = 1'b0;
    endcase
    if ((cnt_d >= CW'(BLANK_CYCLES)) && !(LZ_SUPPRESS && suppress)) begin
      an_d = ~(4'b0001 << idx_d);
    end
    tick_d = (cnt_d == '0) && (idx_d == 2'd0);
  end

  always_ff @(posedge CLK_100MHZ) begin
    if (RST) begin
      cnt_q       <= '0;
      idx_q       <= 2'd0;
      run_q       <= 1'b0;
      pend_full_q <= 1'b0;
      pend_q      <= 16'h0000;
      disp_q      <= 16'h0000;
      an_q        <= 4'hF;
      digit_q     <= 4'h0;
      tick_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      run_q       <= run_d;
      pend_full_q <= pend_full_d;
      pend_q      <= pend_d;
      disp_q      <= disp_d;
      an_q        <= an_d;
      digit_q     <= digit_d;
      tick_q      <= tick_d;
    end
  end

  assign LOAD_READY = ~pend_full_q;
  assign AN         = an_q;
  assign DIGIT      = digit_q;
  assign FRAME_TICK = tick_q;

endmodule

`default_nettype wire
